opll_write_queue: RTL
=====================

OPLL_WRITE_QUEUE -- requirements
Module: opll_write_queue

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_LOG2, default 3, meaning FIFO depth is 2^FIFO_DEPTH_LOG2 entries.
REQ-002 SHALL have parameter ADDR_WAIT, default 12, meaning enable ticks to hold off after an address-register write (A0=0).
REQ-003 SHALL have parameter DATA_WAIT, default 84, meaning enable ticks to hold off after a data-register write (A0=1).
REQ-004 Port: clk  input  1  system clock; sole clock.
REQ-005 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: enable  input  1  OPLL master-clock enable (one-clk pulse per phiM tick).
REQ-007 Ports: bus_ioreq, bus_memreq, bus_write, bus_valid  input  1 each  upstream CPU bus qualifiers.
REQ-008 Ports: bus_address  input  16 and bus_wdata  input  8  upstream address and write data.
REQ-009 Port: bus_ready  output  1  upstream acceptance.
REQ-010 Ports: out_ioreq, out_memreq, out_write, out_valid  output  1 each  downstream bus to the dual OPLL.
REQ-011 Ports: out_address  output  16 and out_wdata  output  8  downstream address and data.
REQ-012 Port: out_ready  input  1  downstream acceptance.
REQ-013 Port: busy  output  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-014 Match: chip 0 = I/O 7Ch/7Dh (bus_address[7:0]) or memory 7FF4h/7FF5h; chip 1 = I/O 7Ah/7Bh or memory 7FF2h/7FF3h; A0 = bus_address[0].
REQ-015 Matching write (bus_valid & bus_write & match) SHALL push {chip, A0, wdata} (10 bits) when bus_valid & bus_ready.
REQ-016 bus_ready SHALL be 0 for a matching write while FIFO full, otherwise 1; non-matching cycles and matching reads SHALL see bus_ready=1 and be ignored.
REQ-017 bus_ready SHALL derive only from registered FIFO count (no path from out_ready); a pop in the same cycle does not free a slot until the next cycle.
REQ-018 FIFO pointers SHALL wrap modulo 2^FIFO_DEPTH_LOG2; count SHALL never exceed depth nor underflow.
REQ-019 FSM states: IDLE, ISSUE, WAIT.
REQ-020 IDLE: FIFO non-empty -> ISSUE next cycle; else stay.
REQ-021 ISSUE: out_valid=1 with head entry; out_ioreq=1, out_memreq=0, out_write=1, out_address = 00_7Ch|A0 (chip 0) or 00_7Ah|A0 (chip 1), out_wdata = entry data; all stable until out_ready.
REQ-022 ISSUE with out_ready=1: pop head, load counter with ADDR_WAIT (A0=0) or DATA_WAIT (A0=1), -> WAIT.
REQ-023 WAIT: counter decrements by 1 on each clk with enable=1; when counter reaches 0 -> IDLE same edge; enable ignored in IDLE/ISSUE.
REQ-024 Wait SHALL be shared by both chips (strictly serial drain, order preserved across chips).
REQ-025 Outside ISSUE, out_valid, out_ioreq, out_write SHALL be 0; out_address, out_wdata SHALL be 0.
REQ-026 Simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-027 Counter width SHALL fit max(ADDR_WAIT, DATA_WAIT); parameter value 0 SHALL mean WAIT exits on first clk.
REQ-028 Minimum issue-to-issue spacing SHALL be 1 + wait + 1 clk (ISSUE accept, WAIT, IDLE).

Reset
REQ-029 reset_n low SHALL immediately clear FIFO (count 0, pointers 0), FSM -> IDLE, counter 0, out_* all 0, busy 0, bus_ready 1.
REQ-030 Reset mid-ISSUE or mid-WAIT SHALL discard pending entries; no partial downstream transaction after release.
REQ-031 First push allowed on the first clk edge after reset_n rises.

Verification
REQ-032 Write 10h to I/O 7Ch then 30h to 7Dh, out_ready=1, enable every 4 clk -> out 007Ch/10h, then ≥12 enable ticks later 007Dh/30h.
REQ-033 Push 9 matching writes with out_ready=0, depth 8 -> 8 accepted, 9th held with bus_ready=0 until first pop, then accepted next cycle; FIFO order preserved.
REQ-034 Memory write 7FF3h data 55h -> out_address 007Bh, out_wdata 55h, chip 1; I/O read of 7Ch and write to 7Eh -> bus_ready=1, nothing queued.
REQ-035 Data write then address write, enable constant 1 -> second out_valid exactly 84+2 clk after first accept.
REQ-036 Assert reset_n=0 during WAIT with 3 entries queued -> same cycle out_valid=0, busy=0; after release no transaction issued.
REQ-037 out_ready held 0 for 20 clk in ISSUE -> out_address/out_wdata/out_valid stable all 20 clk, no pop.

Source files
------------

// File: rtl/opll_write_queue_if.sv
// Single-beat CPU-style bus: request qualifiers, address, write data and a ready.
// The queue accepts one of these upstream and drives another toward the dual OPLL.
interface opll_write_queue_if;
  logic        ioreq;
  logic        memreq;
  logic        write;
  logic        valid;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        ready;

  modport master (output ioreq, memreq, write, valid, address, wdata, input ready);
  modport slave  (input ioreq, memreq, write, valid, address, wdata, output ready);
endinterface

// File: rtl/opll_write_queue.sv
// Write queue for a dual OPLL: buffers register writes for either chip and drains them
// strictly in order, holding off a shared number of enable ticks after each write.
module opll_write_queue #(
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int ADDR_WAIT       = 12,
  parameter int DATA_WAIT       = 84
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  opll_write_queue_if.slave    bus,
  opll_write_queue_if.master   out,
  output logic                 busy
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int WMAX  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW    = (WMAX < 1) ? 1 : $clog2(WMAX + 1);

  typedef struct packed {
    logic       chip;
    logic       a0;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  entry_t                     mem [DEPTH];
  entry_t                     head;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  state_t                     state;
  logic [CW-1:0]              cnt;

  logic chip0, chip1, hit_wr, full, push, pop;

  // I/O decode looks only at the low address byte; memory decode is a full 16-bit match.
  assign chip0  = (bus.ioreq  && bus.address[7:1]  == 7'h3E) ||
                  (bus.memreq && bus.address[15:1] == 15'h3FFA);
  assign chip1  = (bus.ioreq  && bus.address[7:1]  == 7'h3D) ||
                  (bus.memreq && bus.address[15:1] == 15'h3FF9);
  assign hit_wr = bus.valid && bus.write && (chip0 || chip1);
  assign full   = (count == (FIFO_DEPTH_LOG2+1)'(DEPTH));

  // Ready comes only from the registered count, so a pop this cycle frees a slot next cycle.
  assign bus.ready = !(hit_wr && full);
  assign push      = hit_wr && !full;
  assign pop       = (state == ISSUE) && out.ready;
  assign head      = mem[rd_ptr];
  assign busy      = (count != '0) || (state != IDLE);
  assign out.memreq = 1'b0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{chip: chip1, a0: bus.address[0], data: bus.wdata};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      out.valid   <= 1'b0;
      out.ioreq   <= 1'b0;
      out.write   <= 1'b0;
      out.address <= '0;
      out.wdata   <= '0;
    end else begin
      case (state)
        IDLE: if (count != '0) begin
          state       <= ISSUE;
          out.valid   <= 1'b1;
          out.ioreq   <= 1'b1;
          out.write   <= 1'b1;
          out.address <= {8'h00, 5'b01111, ~head.chip, head.chip, head.a0};
          out.wdata   <= head.data;
        end
        ISSUE: if (out.ready) begin
          state       <= WAIT;
          cnt         <= head.a0 ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
          out.valid   <= 1'b0;
          out.ioreq   <= 1'b0;
          out.write   <= 1'b0;
          out.address <= '0;
          out.wdata   <= '0;
        end
        WAIT: begin
          // A zero load leaves on the first clock regardless of enable.
          if (cnt == '0) state <= IDLE;
          else if (enable) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
